// File: rtl/ramb_asym_dp.sv
// True dual-port single-clock RAM with independently sized ports (B = A * 2^k).
// Per-port write modes, optional output pipeline stage and a registered collision flag.
module ramb_asym_dp #(
   parameter int                    MEM_BITS     = 4096,
   parameter int                    WIDTH_A      = 1,
   parameter int                    WIDTH_B      = 16,
   parameter string                 WRITE_MODE_A = "WRITE_FIRST",
   parameter string                 WRITE_MODE_B = "WRITE_FIRST",
   parameter int                    DOA_REG      = 0,
   parameter int                    DOB_REG      = 0,
   parameter logic [WIDTH_A-1:0]    SRVAL_A      = '0,
   parameter logic [WIDTH_B-1:0]    SRVAL_B      = '0,
   parameter logic [MEM_BITS-1:0]   INIT         = '0,
   localparam int                   AW_A         = $clog2(MEM_BITS / WIDTH_A),
   localparam int                   AW_B         = $clog2(MEM_BITS / WIDTH_B)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               ENA,
   input  logic               WEA,
   input  logic [AW_A-1:0]    ADDRA,
   input  logic [WIDTH_A-1:0] DIA,
   output logic [WIDTH_A-1:0] DOA,
   input  logic               ENB,
   input  logic               WEB,
   input  logic [AW_B-1:0]    ADDRB,
   input  logic [WIDTH_B-1:0] DIB,
   output logic [WIDTH_B-1:0] DOB,
   output logic               COLL
);

   localparam int MW    = $clog2(MEM_BITS);
   localparam int LW_A  = $clog2(WIDTH_A);
   localparam int LW_B  = $clog2(WIDTH_B);
   localparam int R_SH  = $clog2(WIDTH_B / WIDTH_A);

   localparam int M_WF = 0;
   localparam int M_RF = 1;
   localparam int M_NC = 2;

   localparam int MODE_A = (WRITE_MODE_A == "WRITE_FIRST") ? M_WF :
                           (WRITE_MODE_A == "READ_FIRST")  ? M_RF :
                           (WRITE_MODE_A == "NO_CHANGE")   ? M_NC : 3;
   localparam int MODE_B = (WRITE_MODE_B == "WRITE_FIRST") ? M_WF :
                           (WRITE_MODE_B == "READ_FIRST")  ? M_RF :
                           (WRITE_MODE_B == "NO_CHANGE")   ? M_NC : 3;

   function automatic bit is_pow2(int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   if (!is_pow2(MEM_BITS) || !is_pow2(WIDTH_A) || !is_pow2(WIDTH_B) ||
       (WIDTH_B < WIDTH_A) || (MEM_BITS < 2 * WIDTH_B)) begin : g_bad_geometry
      $error("ramb_asym_dp: illegal geometry MEM_BITS=%0d WIDTH_A=%0d WIDTH_B=%0d",
             MEM_BITS, WIDTH_A, WIDTH_B);
   end
   if (MODE_A == 3 || MODE_B == 3) begin : g_bad_mode
      $error("ramb_asym_dp: unknown write mode");
   end
   if ((DOA_REG != 0 && DOA_REG != 1) || (DOB_REG != 0 && DOB_REG != 1)) begin : g_bad_reg
      $error("ramb_asym_dp: DOA_REG/DOB_REG must be 0 or 1");
   end

   logic [MEM_BITS-1:0] mem = INIT;

   logic [MW-1:0]      base_a;
   logic [MW-1:0]      base_b;
   logic [WIDTH_A-1:0] rda;
   logic [WIDTH_B-1:0] rdb;
   logic               hit;
   logic [WIDTH_A-1:0] doa1, doa2;
   logic [WIDTH_B-1:0] dob1, dob2;
   logic               coll_q;

   assign base_a = MW'(ADDRA) << LW_A;
   assign base_b = MW'(ADDRB) << LW_B;
   // Reads see the contents from before this edge's writes.
   assign rda    = mem[base_a +: WIDTH_A];
   assign rdb    = mem[base_b +: WIDTH_B];
   // An A word always lies entirely inside exactly one B word.
   assign hit    = (ADDRA >> R_SH) == AW_A'(ADDRB);

   always_ff @(posedge CLK) begin
      // B is written last so it wins on overlapping bits.
      if (ENA && WEA) mem[base_a +: WIDTH_A] <= DIA;
      if (ENB && WEB) mem[base_b +: WIDTH_B] <= DIB;

      if (RST) begin
         doa1   <= SRVAL_A;
         doa2   <= SRVAL_A;
         dob1   <= SRVAL_B;
         dob2   <= SRVAL_B;
         coll_q <= 1'b0;
      end else begin
         doa2   <= doa1;
         dob2   <= dob1;
         coll_q <= ENA && ENB && hit && (WEA || WEB);
         if (ENA) begin
            if (!WEA || MODE_A == M_RF) doa1 <= rda;
            else if (MODE_A == M_WF)    doa1 <= DIA;
         end
         if (ENB) begin
            if (!WEB || MODE_B == M_RF) dob1 <= rdb;
            else if (MODE_B == M_WF)    dob1 <= DIB;
         end
      end
   end

   assign DOA  = (DOA_REG != 0) ? doa2 : doa1;
   assign DOB  = (DOB_REG != 0) ? dob2 : dob1;
   assign COLL = coll_q;

endmodule

// File: tb/tb_ramb_asym_dp.sv
// Bench for ramb_asym_dp: three instances share stimulus (table, hand sequences,
// random) and are compared against a bit-array reference model.
module tb_ramb_asym_dp;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, ena, wea, dia, enb, web;
   logic [11:0] addra;
   logic [7:0]  addrb;
   logic [15:0] dib;

   logic        doa  [3];
   logic [15:0] dob  [3];
   logic        coll [3];

   int n_pass = 0;
   int n_tot  = 0;

   ramb_asym_dp #(
      .MEM_BITS(4096), .WIDTH_A(1), .WIDTH_B(16),
      .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
      .DOA_REG(0), .DOB_REG(0), .SRVAL_A(1'b0), .SRVAL_B(16'h0000), .INIT('0)
   ) u0 (
      .CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa[0]),
      .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob[0]), .COLL(coll[0])
   );

   ramb_asym_dp #(
      .MEM_BITS(4096), .WIDTH_A(1), .WIDTH_B(16),
      .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("NO_CHANGE"),
      .DOA_REG(1), .DOB_REG(1), .SRVAL_A(1'b1), .SRVAL_B(16'hBEEF), .INIT({256{16'h1234}})
   ) u1 (
      .CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa[1]),
      .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob[1]), .COLL(coll[1])
   );

   ramb_asym_dp #(
      .MEM_BITS(4096), .WIDTH_A(1), .WIDTH_B(16),
      .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("READ_FIRST"),
      .DOA_REG(0), .DOB_REG(1), .SRVAL_A(1'b0), .SRVAL_B(16'h00FF), .INIT('0)
   ) u2 (
      .CLK(clk), .RST(rst), .ENA(ena), .WEA(wea), .ADDRA(addra), .DIA(dia), .DOA(doa[2]),
      .ENB(enb), .WEB(web), .ADDRB(addrb), .DIB(dib), .DOB(dob[2]), .COLL(coll[2])
   );

   // Reference model: 0 = write-first, 1 = read-first, 2 = no-change.
   int          mode_a [3] = '{0, 1, 2};
   int          mode_b [3] = '{0, 2, 1};
   int          reg_a  [3] = '{0, 1, 0};
   int          reg_b  [3] = '{0, 1, 1};
   logic        sr_a   [3] = '{1'b0, 1'b1, 1'b0};
   logic [15:0] sr_b   [3] = '{16'h0000, 16'hBEEF, 16'h00FF};

   logic [4095:0] mm [3];
   logic          s1a [3], s2a [3];
   logic [15:0]   s1b [3], s2b [3];
   logic          cm  [3];

   function automatic logic [15:0] pick(int mode, logic [15:0] di, logic [15:0] old,
                                        logic [15:0] hold);
      if (mode == 0) return di;
      if (mode == 1) return old;
      return hold;
   endfunction

   task automatic model_step();
      for (int k = 0; k < 3; k++) begin
         int          wa;
         int          wb;
         logic        olda;
         logic [15:0] oldb;
         logic [15:0] tmp;
         wa   = int'(addra);
         wb   = int'(addrb);
         olda = mm[k][wa];
         oldb = mm[k][wb*16 +: 16];
         s2a[k] = rst ? sr_a[k] : s1a[k];
         s2b[k] = rst ? sr_b[k] : s1b[k];
         if (rst) begin
            s1a[k] = sr_a[k];
            s1b[k] = sr_b[k];
         end else begin
            if (ena) begin
               tmp    = wea ? pick(mode_a[k], {15'b0, dia}, {15'b0, olda}, {15'b0, s1a[k]})
                            : {15'b0, olda};
               s1a[k] = tmp[0];
            end
            if (enb) s1b[k] = web ? pick(mode_b[k], dib, oldb, s1b[k]) : oldb;
         end
         cm[k] = !rst && ena && enb && (wa / 16 == wb) && (wea || web);
         if (ena && wea) mm[k][wa] = dia;
         if (enb && web) mm[k][wb*16 +: 16] = dib;
      end
   endtask

   task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, required %h at %0t", nm, act, exp, $time);
   endtask

   task automatic check_model();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("model u%0d DOA", k), {15'b0, doa[k]},
             {15'b0, (reg_a[k] != 0) ? s2a[k] : s1a[k]});
         chk($sformatf("model u%0d DOB", k), dob[k], (reg_b[k] != 0) ? s2b[k] : s1b[k]);
         chk($sformatf("model u%0d COLL", k), {15'b0, coll[k]}, {15'b0, cm[k]});
      end
   endtask

   task automatic drive(logic r, logic ea, logic wa_i, logic [11:0] aa, logic da,
                        logic eb, logic wb_i, logic [7:0] ab, logic [15:0] db);
      rst = r; ena = ea; wea = wa_i; addra = aa; dia = da;
      enb = eb; web = wb_i; addrb = ab; dib = db;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   typedef struct {
      logic        rst, ena, wea;
      logic [11:0] addra;
      logic        dia, enb, web;
      logic [7:0]  addrb;
      logic [15:0] dib;
      logic        exp_doa;
      logic [15:0] exp_dob;
      logic        exp_coll;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(logic r, logic ea, logic wa_i, logic [11:0] aa, logic da,
                               logic eb, logic wb_i, logic [7:0] ab, logic [15:0] db,
                               logic xa, logic [15:0] xb, logic xc);
      vec_t v;
      v.rst = r; v.ena = ea; v.wea = wa_i; v.addra = aa; v.dia = da;
      v.enb = eb; v.web = wb_i; v.addrb = ab; v.dib = db;
      v.exp_doa = xa; v.exp_dob = xb; v.exp_coll = xc;
      return v;
   endfunction

   initial begin
      logic [15:0] p;
      logic [15:0] q;
      mm[0] = '0;
      mm[1] = {256{16'h1234}};
      mm[2] = '0;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Expected values below are for u0 (write-first, no output register).
      p = 16'h6C2D;
      q = 16'hA5C3;
      vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0, 16'h0000, 0));
      for (int m = 0; m < 16; m++)
         vq.push_back(mk(0, 1, 1, 12'(m), p[m], 0, 0, 0, 16'h0, p[m], 16'h0000, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 16'h0, p[15], p, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, q, p[15], q, 0));
      for (int m = 0; m < 16; m++)
         vq.push_back(mk(0, 1, 0, 12'(16 + m), 0, 0, 0, 0, 16'h0, q[m], q, 0));
      vq.push_back(mk(0, 1, 1, 3, 1, 1, 1, 0, 16'h0000, 1, 16'h0000, 1));
      vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 16'h0, 1, 16'h0000, 0));
      vq.push_back(mk(0, 1, 1, 3, 1, 1, 0, 0, 16'h0, 1, 16'h0000, 1));
      vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 16'h0, 1, 16'h0008, 0));
      vq.push_back(mk(0, 1, 0, 18, 0, 1, 1, 1, 16'hFFFF, 0, 16'hFFFF, 1));
      vq.push_back(mk(0, 1, 1, 19, 0, 1, 0, 1, 16'h0, 0, 16'hFFFF, 1));
      vq.push_back(mk(0, 1, 0, 18, 0, 0, 0, 0, 16'h0, 1, 16'hFFFF, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 16'h0, 1, 16'hFFF7, 0));
      vq.push_back(mk(0, 1, 1, 40, 1, 1, 1, 0, 16'h1234, 1, 16'h1234, 0));
      vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1, 16'h1234, 0));
      vq.push_back(mk(1, 1, 1, 41, 1, 1, 0, 2, 16'h0, 0, 16'h0000, 0));
      vq.push_back(mk(0, 1, 0, 41, 0, 1, 0, 2, 16'h0, 1, 16'h0300, 0));

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].rst, vq[i].ena, vq[i].wea, vq[i].addra, vq[i].dia,
               vq[i].enb, vq[i].web, vq[i].addrb, vq[i].dib);
         cycle();
         chk($sformatf("vec%0d DOA", i), {15'b0, doa[0]}, {15'b0, vq[i].exp_doa});
         chk($sformatf("vec%0d DOB", i), dob[0], vq[i].exp_dob);
         chk($sformatf("vec%0d COLL", i), {15'b0, coll[0]}, {15'b0, vq[i].exp_coll});
      end

      // Write modes on A address 5.
      drive(0, 1, 1, 5, 1, 0, 0, 0, 0);   cycle();
      drive(0, 1, 0, 100, 0, 0, 0, 0, 0); cycle();
      chk("mode nc prior", {15'b0, doa[2]}, 16'h0000);
      drive(0, 1, 1, 5, 0, 0, 0, 0, 0);   cycle();
      chk("mode wf new", {15'b0, doa[0]}, 16'h0000);
      chk("mode nc hold0", {15'b0, doa[2]}, 16'h0000);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);   cycle();
      chk("mode rf old", {15'b0, doa[1]}, 16'h0001);
      drive(0, 1, 0, 5, 0, 0, 0, 0, 0);   cycle();
      chk("mode readback", {15'b0, doa[0]}, 16'h0000);
      drive(0, 1, 1, 5, 1, 0, 0, 0, 0);   cycle();
      chk("mode wf new1", {15'b0, doa[0]}, 16'h0001);
      chk("mode nc hold1", {15'b0, doa[2]}, 16'h0000);

      // Reset arriving while a registered A read is in flight.
      drive(0, 1, 0, 96, 0, 0, 0, 0, 0); cycle();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);  cycle();
      chk("midrst srval", {15'b0, doa[1]}, 16'h0001);
      drive(0, 1, 0, 96, 0, 0, 0, 0, 0); cycle();
      chk("midrst latency", {15'b0, doa[1]}, 16'h0001);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);  cycle();
      chk("midrst data", {15'b0, doa[1]}, 16'h0000);

      // Registered B port through reset: SRVAL, then 2-cycle latency, memory intact.
      drive(0, 0, 0, 0, 0, 1, 1, 2, 16'h1357); cycle();
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 0, 0, 1, 0, 2, 0); cycle();
         chk("pipe rst DOB", dob[1], 16'hBEEF);
         chk("pipe rst COLL", {15'b0, coll[1]}, 16'h0000);
         chk("pipe rst DOA", {15'b0, doa[1]}, 16'h0001);
      end
      drive(0, 0, 0, 0, 0, 1, 0, 2, 0); cycle();
      chk("pipe lat1", dob[1], 16'hBEEF);
      drive(0, 0, 0, 0, 0, 1, 0, 3, 0); cycle();
      chk("pipe lat2", dob[1], 16'h1357);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
      chk("pipe init", dob[1], 16'h1234);

      // Random traffic, biased towards overlapping addresses.
      for (int i = 0; i < 800; i++) begin
         logic [7:0]  rb;
         logic [11:0] ra;
         rb = 8'($urandom);
         ra = ($urandom_range(0, 1) == 1) ? {rb, 4'($urandom)} : 12'($urandom);
         drive(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom), ra, 1'($urandom),
               1'($urandom), 1'($urandom), rb, 16'($urandom));
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
